// File: rtl/scan_chain_seq.sv
// Scan-chain sequencer: shifts patterns into one mux-D chain, pulses capture, unloads responses.
// Optional macro SCAN_SEQ_MISR_EN folds responses into misr_sig instead of streaming them on res_*.
module scan_chain_seq #(
    parameter int          CHAIN_LEN = 32,
    parameter int          CNT_W     = 6,
    parameter logic [31:0] MISR_POLY = 32'h04C11DB7
) (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] num_pat,
    input  logic        pat_valid,
    input  logic        pat_bit,
    output logic        pat_ready,
    output logic        res_valid,
    output logic        res_bit,
    input  logic        res_ready,
    output logic        scan_se,
    output logic        scan_si,
    output logic        scan_clk_en,
    input  logic        scan_so,
    output logic        busy,
    output logic        done,
    output logic [31:0] misr_sig
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_CAPTURE,
        ST_UNLOAD,
        ST_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [15:0]       pat_cnt;
    logic              first;
    logic              rr_eff;
    logic              adv;
    logic              last_bit;
    logic              accept;

`ifdef SCAN_SEQ_MISR_EN
    logic              unused_rr;
    assign unused_rr = res_ready;
    assign rr_eff    = 1'b1;
`else
    logic              unused_poly;
    assign unused_poly = ^MISR_POLY;
    assign rr_eff      = res_ready;
`endif

    assign last_bit = (bit_cnt == LAST_BIT);
    assign accept   = (state == ST_IDLE) && start && !abort;

    always_comb begin
        adv = 1'b0;
        case (state)
            ST_SHIFT:  adv = pat_valid && (rr_eff || first);
            ST_UNLOAD: adv = rr_eff || first;
            default:   adv = 1'b0;
        endcase
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pat_ready   = 1'b0;
        res_valid   = 1'b0;
        res_bit     = 1'b0;
        scan_se     = 1'b0;
        scan_si     = 1'b0;
        scan_clk_en = 1'b0;
        done        = 1'b0;
        busy        = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = (num_pat != 16'd0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                scan_se     = 1'b1;
                scan_si     = pat_bit;
                scan_clk_en = adv;
                pat_ready   = adv;
                res_bit     = scan_so;
`ifndef SCAN_SEQ_MISR_EN
                res_valid   = !first && pat_valid;
`endif
                if (adv && last_bit) begin
                    state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                scan_clk_en = 1'b1;
                state_nxt   = (pat_cnt == 16'd1) ? ST_UNLOAD : ST_SHIFT;
            end
            ST_UNLOAD: begin
                scan_se     = 1'b1;
                scan_clk_en = adv;
                res_bit     = scan_so;
`ifndef SCAN_SEQ_MISR_EN
                res_valid   = 1'b1;
`endif
                if (adv && last_bit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // abort outranks everything, including a start seen in IDLE
        if (abort) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            bit_cnt <= '0;
            pat_cnt <= '0;
            first   <= 1'b0;
        end else if (accept) begin
            bit_cnt <= '0;
            pat_cnt <= num_pat;
            first   <= 1'b1;
        end else begin
            case (state)
                ST_SHIFT, ST_UNLOAD: begin
                    if (adv) begin
                        bit_cnt <= last_bit ? '0 : bit_cnt + CNT_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    first   <= 1'b0;
                    pat_cnt <= pat_cnt - 16'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef SCAN_SEQ_MISR_EN
    logic [31:0] misr_q;

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst || accept) begin
            misr_q <= '0;
        end else if (adv && !first) begin
            misr_q <= {misr_q[30:0], 1'b0} ^ (misr_q[31] ? MISR_POLY : 32'h0)
                      ^ {31'b0, scan_so};
        end
    end

    assign misr_sig = misr_q;
`else
    assign misr_sig = '0;
`endif

endmodule

// File: tb/tb_scan_chain_seq.sv
// Self-checking bench for scan_chain_seq (CHAIN_LEN=4) against a behavioural chain and stream model.
// Define SCAN_SEQ_MISR_EN for both files to exercise the signature build.
module tb_scan_chain_seq;

    localparam int          L    = 4;
    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0;
    logic [15:0] num_pat = '0;
    logic        pat_valid = 1'b0, pat_bit = 1'b0, res_ready = 1'b0;
    logic        pat_ready, res_valid, res_bit, scan_se, scan_si, scan_clk_en, scan_so, busy, done;
    logic [31:0] misr_sig;
    logic [L-1:0] chain = '0;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    scan_chain_seq #(.CHAIN_LEN(L), .CNT_W(3), .MISR_POLY(POLY)) dut (
        .nvdla_core_clk(clk), .nvdla_core_rst(rst), .start(start), .abort(abort),
        .num_pat(num_pat), .pat_valid(pat_valid), .pat_bit(pat_bit), .pat_ready(pat_ready),
        .res_valid(res_valid), .res_bit(res_bit), .res_ready(res_ready),
        .scan_se(scan_se), .scan_si(scan_si), .scan_clk_en(scan_clk_en), .scan_so(scan_so),
        .busy(busy), .done(done), .misr_sig(misr_sig)
    );

    // Environment: gated mux-D chain, capture loads the inverse of each flop.
    assign scan_so = chain[L-1];
    always @(posedge clk) begin
        if (scan_clk_en) begin
            if (scan_se) chain <= {chain[L-2:0], scan_si};
            else         chain <= ~chain;
        end
    end

    bit q_pat[$];
    bit q_res[$];
    bit fixed_pat[$];
    int done_cyc, viol, stall_viol, res_unstable;
    bit tmo;

    function automatic int min_done(input int np);
        return (np == 0) ? 1 : 1 + np * (L + 1) + L;
    endfunction

    // Responses to pattern k are ~pattern k, in shift order.
    function automatic int stream_errs();
        int bad = 0;
        if (q_res.size() != q_pat.size()) return -1;
        foreach (q_pat[i]) if (q_res[i] !== ~q_pat[i]) bad++;
        return bad;
    endfunction

    function automatic logic [31:0] misr_ref();
        logic [31:0] m = '0;
        foreach (q_pat[i]) m = {m[30:0], 1'b0} ^ (m[31] ? POLY : 32'h0) ^ {31'b0, ~q_pat[i]};
        return m;
    endfunction

    task automatic run_engine(input int np, input int pv_pct, input int rr_pct,
                              input int pv_stall_at, input int rr_stall_at, input int stall_len,
                              input bit busy_start);
        logic held = 1'b0;
        q_pat.delete(); q_res.delete();
        done_cyc = -1; tmo = 0; viol = 0; stall_viol = 0; res_unstable = 0;
        @(negedge clk);
        start = 1'b1; num_pat = np[15:0]; abort = 1'b0; pat_valid = 1'b0; res_ready = 1'b0;
        @(negedge clk);
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            start     = busy_start ? 1'($urandom_range(0, 1)) : 1'b0;
            if (busy_start) num_pat = 16'($urandom_range(0, 9));
            pat_valid = ($urandom_range(0, 99) < pv_pct);
            if (pv_stall_at > 0 && cyc >= pv_stall_at && cyc < pv_stall_at + stall_len) pat_valid = 1'b0;
            pat_bit   = (fixed_pat.size() > 0) ? fixed_pat[0] : 1'($urandom_range(0, 1));
            res_ready = ($urandom_range(0, 99) < rr_pct);
            if (rr_stall_at > 0 && cyc >= rr_stall_at && cyc < rr_stall_at + stall_len) res_ready = 1'b0;
            #1;
            if (!busy) viol++;
            if (pat_ready && !pat_valid) viol++;
`ifdef SCAN_SEQ_MISR_EN
            if (res_valid) viol++;
`endif
            if (pv_stall_at > 0 && cyc >= pv_stall_at && cyc < pv_stall_at + stall_len)
                if (scan_clk_en || pat_ready) stall_viol++;
            if (rr_stall_at > 0 && cyc >= rr_stall_at && cyc < rr_stall_at + stall_len) begin
                if (scan_clk_en) stall_viol++;
                if (cyc == rr_stall_at) held = res_bit;
                else if (res_bit !== held) res_unstable++;
            end
            if (pat_valid && pat_ready) begin
                q_pat.push_back(pat_bit);
                if (fixed_pat.size() > 0) void'(fixed_pat.pop_front());
            end
            if (res_valid && res_ready) q_res.push_back(res_bit);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (done_cyc < 0) tmo = 1;
        start = 1'b0; pat_valid = 1'b0; res_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({pat_ready, res_valid, res_bit, scan_se, scan_si, scan_clk_en, busy, done} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b want=00000000",
                     {pat_ready, res_valid, res_bit, scan_se, scan_si, scan_clk_en, busy, done});
        end
        n_cmp++;
        if (misr_sig !== 32'h0) begin n_fail++; $display("FAIL reset_misr got=%h want=0", misr_sig); end
    endtask

    task automatic test_zero_pat();
        run_engine(0, 100, 100, 0, 0, 0, 0);
        n_cmp++;
        if (tmo || done_cyc !== 1) begin n_fail++; $display("FAIL zero_pat_done got=%0d want=1", done_cyc); end
        n_cmp++;
        if (q_pat.size() + q_res.size() !== 0) begin
            n_fail++; $display("FAIL zero_pat_traffic got=%0d want=0", q_pat.size() + q_res.size());
        end
    endtask

    task automatic test_basic();
        run_engine(2, 100, 100, 0, 0, 0, 0);
        n_cmp++;
        if (tmo || done_cyc !== min_done(2)) begin
            n_fail++; $display("FAIL basic_done got=%0d want=%0d", done_cyc, min_done(2));
        end
        n_cmp++;
        if (q_pat.size() !== 2 * L || viol !== 0) begin
            n_fail++; $display("FAIL basic_pat got=%0d/viol%0d want=%0d/viol0", q_pat.size(), viol, 2 * L);
        end
`ifndef SCAN_SEQ_MISR_EN
        n_cmp++;
        if (stream_errs() !== 0) begin n_fail++; $display("FAIL basic_stream got=%0d errs want=0", stream_errs()); end
`endif
    endtask

    task automatic test_stall();
        run_engine(3, 100, 100, 2, 0, 3, 0);
        n_cmp++;
        if (tmo || done_cyc !== min_done(3) + 3) begin
            n_fail++; $display("FAIL stall_done got=%0d want=%0d", done_cyc, min_done(3) + 3);
        end
        n_cmp++;
        if (stall_viol !== 0) begin n_fail++; $display("FAIL stall_hold got=%0d want=0", stall_viol); end
`ifndef SCAN_SEQ_MISR_EN
        n_cmp++;
        if (stream_errs() !== 0) begin n_fail++; $display("FAIL stall_stream got=%0d errs want=0", stream_errs()); end
`endif
    endtask

`ifndef SCAN_SEQ_MISR_EN
    task automatic test_backpressure();
        run_engine(2, 100, 100, 0, min_done(2) - L + 1, 5, 0);
        n_cmp++;
        if (tmo || done_cyc !== min_done(2) + 5) begin
            n_fail++; $display("FAIL bp_done got=%0d want=%0d", done_cyc, min_done(2) + 5);
        end
        n_cmp++;
        if (stall_viol !== 0 || res_unstable !== 0) begin
            n_fail++; $display("FAIL bp_hold got=%0d/%0d want=0/0", stall_viol, res_unstable);
        end
        n_cmp++;
        if (stream_errs() !== 0) begin n_fail++; $display("FAIL bp_stream got=%0d errs want=0", stream_errs()); end
    endtask
`endif

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            int np = $urandom_range(1, 5);
            run_engine(np, 60, 60, 0, 0, 0, 0);
            n_cmp++;
            if (tmo || done_cyc < min_done(np) || viol !== 0 || q_pat.size() !== np * L) begin
                n_fail++;
                $display("FAIL rand_run%0d done=%0d viol=%0d pat=%0d want done>=%0d viol=0 pat=%0d",
                         r, done_cyc, viol, q_pat.size(), min_done(np), np * L);
            end
`ifdef SCAN_SEQ_MISR_EN
            n_cmp++;
            if (misr_sig !== misr_ref()) begin
                n_fail++; $display("FAIL rand_misr%0d got=%h want=%h", r, misr_sig, misr_ref());
            end
`else
            n_cmp++;
            if (stream_errs() !== 0) begin
                n_fail++; $display("FAIL rand_stream%0d got=%0d errs want=0", r, stream_errs());
            end
`endif
        end
    endtask

    task automatic test_start_while_busy();
        run_engine(2, 100, 100, 0, 0, 0, 1);
        n_cmp++;
        if (tmo || done_cyc !== min_done(2) || q_pat.size() !== 2 * L) begin
            n_fail++; $display("FAIL busy_start got=%0d/%0d want=%0d/%0d", done_cyc, q_pat.size(), min_done(2), 2 * L);
        end
    endtask

    task automatic test_abort();
        int dones = 0;
        @(negedge clk);
        start = 1'b1; num_pat = 16'd2; pat_valid = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (L) @(negedge clk);
        #1;
        n_cmp++;
        if (scan_se !== 1'b0 || scan_clk_en !== 1'b1) begin
            n_fail++; $display("FAIL abort_in_capture se/en got=%b%b want=01", scan_se, scan_clk_en);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0; pat_valid = 1'b0;
        #1;
        n_cmp++;
        if ({busy, scan_se, scan_clk_en, done, pat_ready, res_valid} !== 6'b0) begin
            n_fail++; $display("FAIL abort_idle got=%b want=000000", {busy, scan_se, scan_clk_en, done, pat_ready, res_valid});
        end
        repeat (10) begin
            @(negedge clk); #1;
            if (done || busy) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin n_fail++; $display("FAIL abort_no_done got=%0d want=0", dones); end
        run_engine(1, 100, 100, 0, 0, 0, 0);
        n_cmp++;
        if (tmo || done_cyc !== min_done(1)) begin
            n_fail++; $display("FAIL abort_rerun got=%0d want=%0d", done_cyc, min_done(1));
        end
        // abort on the same cycle as start wins
        @(negedge clk);
        start = 1'b1; abort = 1'b1; num_pat = 16'd1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_with_start busy got=%b want=0", busy); end
    endtask

    task automatic test_reset_midrun();
        @(negedge clk);
        start = 1'b1; num_pat = 16'd3; pat_valid = 1'b1; res_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; pat_valid = 1'b0; res_ready = 1'b0;
        #1;
        n_cmp++;
        if ({busy, scan_se, scan_clk_en, done, pat_ready, res_valid} !== 6'b0 || misr_sig !== 32'h0) begin
            n_fail++; $display("FAIL reset_midrun got=%b misr=%h want=000000 misr=0",
                               {busy, scan_se, scan_clk_en, done, pat_ready, res_valid}, misr_sig);
        end
        run_engine(2, 100, 100, 0, 0, 0, 0);
        n_cmp++;
        if (tmo || done_cyc !== min_done(2)) begin
            n_fail++; $display("FAIL reset_rerun got=%0d want=%0d", done_cyc, min_done(2));
        end
    endtask

`ifdef SCAN_SEQ_MISR_EN
    task automatic test_misr();
        logic [3:0] pa = 4'b1010;
        logic [3:0] pb = 4'b0110;
        fixed_pat.delete();
        for (int i = 3; i >= 0; i--) fixed_pat.push_back(pa[i]);
        for (int i = 3; i >= 0; i--) fixed_pat.push_back(pb[i]);
        run_engine(2, 100, 100, 0, 0, 0, 0);
        n_cmp++;
        if (tmo || viol !== 0) begin n_fail++; $display("FAIL misr_run tmo=%0d viol=%0d want 0/0", tmo, viol); end
        @(negedge clk); #1;
        n_cmp++;
        if (misr_sig !== misr_ref()) begin n_fail++; $display("FAIL misr_sig got=%h want=%h", misr_sig, misr_ref()); end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_pat();
        test_basic();
        test_stall();
`ifndef SCAN_SEQ_MISR_EN
        test_backpressure();
`endif
        test_random();
        test_start_while_busy();
        test_abort();
        test_reset_midrun();
`ifdef SCAN_SEQ_MISR_EN
        test_misr();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
